// File: rtl/v2p_ceu_req_dec.sv
// rtl/v2p_ceu_req_dec.sv - CEU write-request decoder at the V2P ingress
//
// Decodes head+payload packets from the CEU write-request stream and turns
// them into single table commands for the V2P tables.
//   clk, rst                    : sole clock, asynchronous active-high reset
//   ceu_req_*                   : request stream (head valid on first beat only)
//   mtt_wr_*                    : one 64-bit MTT entry write per handshake
//   icm_map_*                   : one {virt, phys} ICM chunk per handshake
//   icm_unmap_*                 : ICM unmap command (virt, count)
//   mpt_wr_*                    : MPT context beats, forwarded as-is
//   mpt_inv_*                   : MPT invalidate command (index)
//   err_pulse                   : one-cycle pulse on a malformed/unknown packet
module v2p_ceu_req_dec #(
    parameter int TYPE_W   = 4,
    parameter int OPCODE_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ceu_req_valid,
    output logic         ceu_req_ready,
    input  logic         ceu_req_last,
    input  logic [127:0] ceu_req_head,
    input  logic [255:0] ceu_req_data,
    output logic         mtt_wr_valid,
    input  logic         mtt_wr_ready,
    output logic [63:0]  mtt_wr_index,
    output logic [63:0]  mtt_wr_data,
    output logic         icm_map_valid,
    input  logic         icm_map_ready,
    output logic [63:0]  icm_map_virt,
    output logic [63:0]  icm_map_phys,
    output logic         icm_unmap_valid,
    input  logic         icm_unmap_ready,
    output logic [63:0]  icm_unmap_virt,
    output logic [31:0]  icm_unmap_cnt,
    output logic         mpt_wr_valid,
    input  logic         mpt_wr_ready,
    output logic         mpt_wr_last,
    output logic [31:0]  mpt_wr_index,
    output logic [255:0] mpt_wr_data,
    output logic         mpt_inv_valid,
    input  logic         mpt_inv_ready,
    output logic [31:0]  mpt_inv_index,
    output logic         err_pulse
);

    localparam logic [TYPE_W-1:0]   WR_MPT_TPT     = TYPE_W'(1);
    localparam logic [TYPE_W-1:0]   WR_MTT_TPT     = TYPE_W'(2);
    localparam logic [TYPE_W-1:0]   MAP_ICM_TPT    = TYPE_W'(3);
    localparam logic [OPCODE_W-1:0] WR_MPT_WRITE   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] WR_MPT_INVALID = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] WR_MTT_WRITE   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] MAP_ICM_EN     = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] MAP_ICM_DIS    = OPCODE_W'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_MTT_SPLIT, S_ICM_SPLIT, S_MPT_FWD, S_BARE, S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [63:0] lo_q, lo_d;
    logic [63:0] idx_q, idx_d;
    logic [31:0] rem_q, rem_d;
    logic [1:0]  sub_q, sub_d;     // k (MTT, 0..3) or j (ICM, bit 0)
    logic        inv_q, inv_d;     // BARE flavour: 1 = MPT invalidate, 0 = ICM unmap
    logic        err_q, err_d;

    logic [TYPE_W-1:0]   head_type;
    logic [OPCODE_W-1:0] head_op;
    logic [31:0]         head_cnt;
    logic                unused_head;
    logic                last_sub;
    logic                beat_end;
    logic                split_hs;
    logic                bare_hs;

    assign head_type   = ceu_req_head[127 -: TYPE_W];
    assign head_op     = ceu_req_head[127-TYPE_W -: OPCODE_W];
    assign head_cnt    = ceu_req_head[95:64];
    assign unused_head = ^ceu_req_head[127-TYPE_W-OPCODE_W:96];

    // The current beat is released on its last chunk or on the final entry.
    assign last_sub = (state_q == S_MTT_SPLIT) ? (sub_q == 2'd3) : sub_q[0];
    assign beat_end = last_sub || (rem_q == 32'd1);
    assign split_hs = (state_q == S_MTT_SPLIT) ? mtt_wr_ready : icm_map_ready;
    assign bare_hs  = inv_q ? mpt_inv_ready : icm_unmap_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            sub_q   <= '0;
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            sub_q   <= sub_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        sub_d   = sub_q;
        inv_d   = inv_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ceu_req_valid) begin
                    cnt_d = head_cnt;
                    lo_d  = ceu_req_head[63:0];
                    idx_d = ceu_req_head[63:0];
                    rem_d = head_cnt;
                    sub_d = 2'd0;
                    inv_d = 1'b0;
                    if (head_type == MAP_ICM_TPT && head_op == MAP_ICM_EN) begin
                        state_d = (head_cnt == 32'd0) ? S_DRAIN : S_ICM_SPLIT;
                    end else if (head_type == MAP_ICM_TPT && head_op == MAP_ICM_DIS) begin
                        state_d = S_BARE;
                    end else if (head_type == WR_MPT_TPT && head_op == WR_MPT_WRITE) begin
                        state_d = S_MPT_FWD;
                    end else if (head_type == WR_MPT_TPT && head_op == WR_MPT_INVALID) begin
                        state_d = S_BARE;
                        inv_d   = 1'b1;
                    end else if (head_type == WR_MTT_TPT && head_op == WR_MTT_WRITE) begin
                        state_d = (head_cnt == 32'd0) ? S_DRAIN : S_MTT_SPLIT;
                    end else begin
                        state_d = S_DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            S_MTT_SPLIT, S_ICM_SPLIT: begin
                if (split_hs) begin
                    idx_d = idx_q + 64'd1;
                    rem_d = rem_q - 32'd1;
                    sub_d = (state_q == S_MTT_SPLIT) ? sub_q + 2'd1 : {1'b0, ~sub_q[0]};
                    if (rem_q == 32'd1) begin
                        // Count satisfied: leftover beats, if any, are drained silently.
                        state_d = ceu_req_last ? S_IDLE : S_DRAIN;
                    end else if (beat_end && ceu_req_last) begin
                        // Packet ended before the advertised count was reached.
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_MPT_FWD: begin
                if (ceu_req_valid && mpt_wr_ready && ceu_req_last) begin
                    state_d = S_IDLE;
                end
            end
            S_BARE: begin
                if (bare_hs) begin
                    state_d = ceu_req_last ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ceu_req_valid && ceu_req_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ceu_req_ready   = 1'b0;
        mtt_wr_valid    = 1'b0;
        mtt_wr_index    = '0;
        mtt_wr_data     = '0;
        icm_map_valid   = 1'b0;
        icm_map_virt    = '0;
        icm_map_phys    = '0;
        icm_unmap_valid = 1'b0;
        icm_unmap_virt  = '0;
        icm_unmap_cnt   = '0;
        mpt_wr_valid    = 1'b0;
        mpt_wr_last     = 1'b0;
        mpt_wr_index    = '0;
        mpt_wr_data     = '0;
        mpt_inv_valid   = 1'b0;
        mpt_inv_index   = '0;
        case (state_q)
            S_MTT_SPLIT: begin
                mtt_wr_valid  = 1'b1;
                mtt_wr_index  = idx_q;
                mtt_wr_data   = ceu_req_data[{sub_q, 6'd0} +: 64];
                ceu_req_ready = mtt_wr_ready && beat_end;
            end
            S_ICM_SPLIT: begin
                icm_map_valid = 1'b1;
                icm_map_virt  = ceu_req_data[{sub_q[0], 7'd0} +: 64];
                icm_map_phys  = ceu_req_data[{sub_q[0], 7'd64} +: 64];
                ceu_req_ready = icm_map_ready && beat_end;
            end
            S_MPT_FWD: begin
                mpt_wr_valid  = ceu_req_valid;
                mpt_wr_last   = ceu_req_last;
                mpt_wr_data   = ceu_req_data;
                mpt_wr_index  = cnt_q;
                ceu_req_ready = mpt_wr_ready;
            end
            S_BARE: begin
                if (inv_q) begin
                    mpt_inv_valid = 1'b1;
                    mpt_inv_index = cnt_q;
                    ceu_req_ready = mpt_inv_ready;
                end else begin
                    icm_unmap_valid = 1'b1;
                    icm_unmap_virt  = lo_q;
                    icm_unmap_cnt   = cnt_q;
                    ceu_req_ready   = icm_unmap_ready;
                end
            end
            S_DRAIN: ceu_req_ready = 1'b1;
            default: ceu_req_ready = 1'b0;
        endcase
    end

    assign err_pulse = err_q;

endmodule

// File: tb/tb_v2p_ceu_req_dec.sv
// tb/tb_v2p_ceu_req_dec.sv - randomized self-checking bench for v2p_ceu_req_dec
module tb_v2p_ceu_req_dec;

    localparam logic [3:0] T_MPT = 4'd1, T_MTT = 4'd2, T_ICM = 4'd3;
    localparam logic [3:0] O_MPT_WR = 4'd1, O_MPT_INV = 4'd2, O_MTT_WR = 4'd1;
    localparam logic [3:0] O_ICM_EN = 4'd1, O_ICM_DIS = 4'd2;
    localparam logic [2:0] CH_MTT = 3'd1, CH_ICM = 3'd2, CH_UNMAP = 3'd3, CH_MPT = 3'd4, CH_INV = 3'd5;

    typedef struct packed {
        logic [2:0]   ch;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [255:0] d;
        logic         l;
        logic         p;   // upstream beat popped on the same cycle
    } rec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ceu_req_valid, ceu_req_ready, ceu_req_last;
    logic [127:0] ceu_req_head;
    logic [255:0] ceu_req_data;
    logic         mtt_wr_valid, mtt_wr_ready;
    logic [63:0]  mtt_wr_index, mtt_wr_data;
    logic         icm_map_valid, icm_map_ready;
    logic [63:0]  icm_map_virt, icm_map_phys;
    logic         icm_unmap_valid, icm_unmap_ready;
    logic [63:0]  icm_unmap_virt;
    logic [31:0]  icm_unmap_cnt;
    logic         mpt_wr_valid, mpt_wr_ready, mpt_wr_last;
    logic [31:0]  mpt_wr_index;
    logic [255:0] mpt_wr_data;
    logic         mpt_inv_valid, mpt_inv_ready;
    logic [31:0]  mpt_inv_index;
    logic         err_pulse;

    always #5 clk = ~clk;

    v2p_ceu_req_dec #(.TYPE_W(4), .OPCODE_W(4)) dut (
        .clk(clk), .rst(rst),
        .ceu_req_valid(ceu_req_valid), .ceu_req_ready(ceu_req_ready), .ceu_req_last(ceu_req_last),
        .ceu_req_head(ceu_req_head), .ceu_req_data(ceu_req_data),
        .mtt_wr_valid(mtt_wr_valid), .mtt_wr_ready(mtt_wr_ready),
        .mtt_wr_index(mtt_wr_index), .mtt_wr_data(mtt_wr_data),
        .icm_map_valid(icm_map_valid), .icm_map_ready(icm_map_ready),
        .icm_map_virt(icm_map_virt), .icm_map_phys(icm_map_phys),
        .icm_unmap_valid(icm_unmap_valid), .icm_unmap_ready(icm_unmap_ready),
        .icm_unmap_virt(icm_unmap_virt), .icm_unmap_cnt(icm_unmap_cnt),
        .mpt_wr_valid(mpt_wr_valid), .mpt_wr_ready(mpt_wr_ready), .mpt_wr_last(mpt_wr_last),
        .mpt_wr_index(mpt_wr_index), .mpt_wr_data(mpt_wr_data),
        .mpt_inv_valid(mpt_inv_valid), .mpt_inv_ready(mpt_inv_ready),
        .mpt_inv_index(mpt_inv_index),
        .err_pulse(err_pulse)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pkt_no = 0;

    logic [3:0]   p_type, p_op;
    logic [31:0]  p_cnt;
    logic [63:0]  p_lo;
    int           p_nb;
    logic [255:0] p_beats [8];
    int           beat_i;
    bit           active;
    int           rdy_mode;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   exp_err, obs_err, first_v_cyc;
    rec_t prev_rec [6];
    logic prev_v [6];
    logic prev_r [6];

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit is_known(input logic [3:0] t, input logic [3:0] o);
        return (t == T_MTT && o == O_MTT_WR) || (t == T_ICM && (o == O_ICM_EN || o == O_ICM_DIS)) ||
               (t == T_MPT && (o == O_MPT_WR || o == O_MPT_INV));
    endfunction

    task automatic set_readies();
        case (rdy_mode)
            0: {mtt_wr_ready, icm_map_ready, icm_unmap_ready, mpt_wr_ready, mpt_inv_ready} = 5'b11111;
            1: {mtt_wr_ready, icm_map_ready, icm_unmap_ready, mpt_wr_ready, mpt_inv_ready} =
                   ~{mtt_wr_ready, icm_map_ready, icm_unmap_ready, mpt_wr_ready, mpt_inv_ready};
            2: begin
                mtt_wr_ready    = ($urandom_range(0, 3) != 0);
                icm_map_ready   = ($urandom_range(0, 3) != 0);
                icm_unmap_ready = ($urandom_range(0, 3) != 0);
                mpt_wr_ready    = ($urandom_range(0, 3) != 0);
                mpt_inv_ready   = ($urandom_range(0, 3) != 0);
            end
            default: {mtt_wr_ready, icm_map_ready, icm_unmap_ready, mpt_wr_ready, mpt_inv_ready} = 5'($urandom);
        endcase
    endtask

    task automatic drive_beat();
        if (beat_i < p_nb) begin
            ceu_req_valid = 1'b1;
            ceu_req_data  = p_beats[beat_i];
            ceu_req_last  = (beat_i == p_nb - 1);
            ceu_req_head  = (beat_i == 0) ? {p_type, p_op, 24'($urandom), p_cnt, p_lo}
                                          : {$urandom, $urandom, $urandom, $urandom};
        end else begin
            ceu_req_valid = 1'b0;
            ceu_req_last  = 1'b0;
            active        = 1'b0;
        end
    endtask

    // One clock: observe at the falling edge, change inputs just after the rising edge.
    task automatic step();
        rec_t cur [6];
        logic v [6];
        logic r [6];
        rec_t t;
        logic pop;
        @(negedge clk);
        cyc++;
        for (int c = 0; c < 6; c++) begin
            cur[c] = '0;
            v[c]   = 1'b0;
            r[c]   = 1'b0;
        end
        v[1] = mtt_wr_valid;    r[1] = mtt_wr_ready;    cur[1].ch = CH_MTT;
        cur[1].a = mtt_wr_index;     cur[1].b = mtt_wr_data;
        v[2] = icm_map_valid;   r[2] = icm_map_ready;   cur[2].ch = CH_ICM;
        cur[2].a = icm_map_virt;     cur[2].b = icm_map_phys;
        v[3] = icm_unmap_valid; r[3] = icm_unmap_ready; cur[3].ch = CH_UNMAP;
        cur[3].a = icm_unmap_virt;   cur[3].b = 64'(icm_unmap_cnt);
        v[4] = mpt_wr_valid;    r[4] = mpt_wr_ready;    cur[4].ch = CH_MPT;
        cur[4].a = 64'(mpt_wr_index); cur[4].d = mpt_wr_data; cur[4].l = mpt_wr_last;
        v[5] = mpt_inv_valid;   r[5] = mpt_inv_ready;   cur[5].ch = CH_INV;
        cur[5].a = 64'(mpt_inv_index);
        pop = ceu_req_valid && ceu_req_ready;
        check_eq("onehot_valid", 512'($countones({v[1], v[2], v[3], v[4], v[5]}) <= 1), 512'(1));
        for (int c = 1; c < 6; c++) begin
            if (prev_v[c] && !prev_r[c])
                check_eq($sformatf("hold ch%0d", c), 512'({v[c], cur[c]}), 512'({1'b1, prev_rec[c]}));
            if (v[c] && r[c]) begin
                t   = cur[c];
                t.p = pop;
                obs_q.push_back(t);
            end
            if (v[c] && first_v_cyc < 0) first_v_cyc = cyc;
            prev_v[c]   = v[c];
            prev_r[c]   = r[c];
            prev_rec[c] = cur[c];
        end
        if (err_pulse) obs_err++;
        @(posedge clk);
        #1;
        if (pop && active) begin
            beat_i++;
            drive_beat();
        end
        set_readies();
    endtask

    // Expected command list from the packet rules alone.
    task automatic model();
        rec_t t;
        int   per, cap, n;
        exp_q.delete();
        exp_err = 0;
        if ((p_type == T_MTT && p_op == O_MTT_WR) || (p_type == T_ICM && p_op == O_ICM_EN)) begin
            per = (p_type == T_MTT) ? 4 : 2;
            cap = per * p_nb;
            n   = (p_cnt > 32'(cap)) ? cap : int'(p_cnt);
            if (p_cnt > 32'(cap)) exp_err = 1;
            for (int e = 0; e < n; e++) begin
                t   = '0;
                t.p = ((e % per) == per - 1) || (32'(e) == p_cnt - 32'd1);
                if (per == 4) begin
                    t.ch = CH_MTT;
                    t.a  = p_lo + 64'(e);
                    t.b  = p_beats[e / 4][64 * (e % 4) +: 64];
                end else begin
                    t.ch = CH_ICM;
                    t.a  = p_beats[e / 2][128 * (e % 2) +: 64];
                    t.b  = p_beats[e / 2][128 * (e % 2) + 64 +: 64];
                end
                exp_q.push_back(t);
            end
        end else if (p_type == T_MPT && p_op == O_MPT_WR) begin
            for (int i = 0; i < p_nb; i++) begin
                t    = '0;
                t.ch = CH_MPT;
                t.a  = 64'(p_cnt);
                t.d  = p_beats[i];
                t.l  = (i == p_nb - 1);
                t.p  = 1'b1;
                exp_q.push_back(t);
            end
        end else if (p_type == T_ICM && p_op == O_ICM_DIS) begin
            t = '0; t.ch = CH_UNMAP; t.a = p_lo; t.b = 64'(p_cnt); t.p = 1'b1;
            exp_q.push_back(t);
        end else if (p_type == T_MPT && p_op == O_MPT_INV) begin
            t = '0; t.ch = CH_INV; t.a = 64'(p_cnt); t.p = 1'b1;
            exp_q.push_back(t);
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic set_pkt(input logic [3:0] t, input logic [3:0] o, input logic [31:0] c,
                           input logic [63:0] lo, input int nb);
        p_type = t; p_op = o; p_cnt = c; p_lo = lo; p_nb = nb;
        for (int i = 0; i < 8; i++) p_beats[i] = rand256();
    endtask

    task automatic run_packet();
        int budget;
        int start;
        int n;
        model();
        obs_q.delete();
        obs_err     = 0;
        first_v_cyc = -1;
        beat_i      = 0;
        active      = 1'b1;
        drive_beat();
        #1;
        check_eq($sformatf("pkt%0d idle_ready", pkt_no), 512'(ceu_req_ready), 512'(0));
        start  = cyc + 1;
        budget = 0;
        while (active && budget < 400) begin
            step();
            budget++;
        end
        repeat (3) step();
        if (active) begin
            check_eq($sformatf("pkt%0d timeout", pkt_no), 512'(0), 512'(1));
            rst = 1'b1;
            ceu_req_valid = 1'b0;
            active = 1'b0;
            step();
            rst = 1'b0;
        end
        check_eq($sformatf("pkt%0d n_cmds", pkt_no), 512'(obs_q.size()), 512'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("pkt%0d cmd%0d", pkt_no, i), 512'(obs_q[i]), 512'(exp_q[i]));
        check_eq($sformatf("pkt%0d err_cnt", pkt_no), 512'(obs_err), 512'(exp_err));
        if (exp_q.size() > 0)
            check_eq($sformatf("pkt%0d latency", pkt_no), 512'(first_v_cyc - start), 512'(1));
        pkt_no++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rt, ro;
        int sel;
        rst = 1'b1;
        ceu_req_valid = 1'b0; ceu_req_last = 1'b0; ceu_req_head = '0; ceu_req_data = '0;
        {mtt_wr_ready, icm_map_ready, icm_unmap_ready, mpt_wr_ready, mpt_inv_ready} = 5'b0;
        active = 1'b0; rdy_mode = 0;
        for (int c = 0; c < 6; c++) begin prev_v[c] = 1'b0; prev_r[c] = 1'b0; prev_rec[c] = '0; end
        #2;
        check_eq("rst_ctl", 512'({ceu_req_ready, mtt_wr_valid, icm_map_valid, icm_unmap_valid,
                                  mpt_wr_valid, mpt_wr_last, mpt_inv_valid, err_pulse}), 512'(0));
        check_eq("rst_fields", 512'({mtt_wr_index, mtt_wr_data, icm_map_virt, icm_map_phys,
                                     icm_unmap_virt, icm_unmap_cnt, mpt_wr_index, mpt_inv_index}), 512'(0));
        check_eq("rst_mpt_data", 512'(mpt_wr_data), 512'(0));
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("idle_ctl", 512'({ceu_req_ready, mtt_wr_valid, icm_map_valid, icm_unmap_valid,
                                   mpt_wr_valid, mpt_inv_valid, err_pulse}), 512'(0));

        rdy_mode = 0; set_pkt(T_MTT, O_MTT_WR, 32'd6, 64'h100, 2); run_packet();
        rdy_mode = 1; set_pkt(T_ICM, O_ICM_EN, 32'd3, 64'h0, 2); run_packet();
        rdy_mode = 0; set_pkt(T_MPT, O_MPT_WR, 32'h2A, 64'h0, 8); run_packet();
        set_pkt(T_MPT, O_MPT_INV, 32'h2A, 64'h0, 1); run_packet();
        set_pkt(T_ICM, O_ICM_DIS, 32'd16, 64'hDEAD_0000, 1); run_packet();
        set_pkt(4'hF, 4'h0, 32'd5, 64'h0, 3); run_packet();
        set_pkt(T_MTT, O_MTT_WR, 32'd8, 64'h40, 1); run_packet();
        set_pkt(T_MTT, O_MTT_WR, 32'd1, 64'h80, 2); run_packet();
        set_pkt(T_MTT, O_MTT_WR, 32'd0, 64'h80, 2); run_packet();
        set_pkt(T_ICM, O_ICM_EN, 32'd0, 64'h0, 1); run_packet();
        set_pkt(T_MTT, O_MTT_WR, 32'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1); run_packet();
        rdy_mode = 3; set_pkt(T_ICM, O_ICM_EN, 32'd4, 64'h0, 2); run_packet();

        // Reset asserted while the second MTT entry is being offered.
        rdy_mode = 0;
        set_pkt(T_MTT, O_MTT_WR, 32'd8, {$urandom, $urandom}, 2);
        obs_q.delete();
        beat_i = 0; active = 1'b1; drive_beat();
        for (int b = 0; b < 20 && obs_q.size() < 1; b++) step();
        check_eq("rst_mid_entry2_valid", 512'({mtt_wr_valid, mtt_wr_index}), 512'({1'b1, p_lo + 64'd1}));
        rst = 1'b1;
        #1;
        check_eq("rst_mid_async", 512'({ceu_req_ready, mtt_wr_valid, icm_map_valid, icm_unmap_valid,
                                        mpt_wr_valid, mpt_inv_valid, mtt_wr_index, mtt_wr_data}), 512'(0));
        ceu_req_valid = 1'b0; ceu_req_last = 1'b0; active = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        set_pkt(T_MTT, O_MTT_WR, 32'd5, {$urandom, $urandom}, 2); run_packet();

        for (int k = 0; k < 150; k++) begin
            rdy_mode = $urandom_range(0, 3);
            sel = $urandom_range(0, 5);
            case (sel)
                0: set_pkt(T_MTT, O_MTT_WR, 32'd0, 64'd0, $urandom_range(1, 4));
                1: set_pkt(T_ICM, O_ICM_EN, 32'd0, 64'd0, $urandom_range(1, 4));
                2: set_pkt(T_ICM, O_ICM_DIS, 32'd0, 64'd0, $urandom_range(1, 3));
                3: set_pkt(T_MPT, O_MPT_WR, 32'd0, 64'd0, $urandom_range(1, 8));
                4: set_pkt(T_MPT, O_MPT_INV, 32'd0, 64'd0, $urandom_range(1, 3));
                default: begin
                    rt = 4'($urandom); ro = 4'($urandom);
                    while (is_known(rt, ro)) begin rt = 4'($urandom); ro = 4'($urandom); end
                    set_pkt(rt, ro, 32'd0, 64'd0, $urandom_range(1, 3));
                end
            endcase
            p_cnt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 18));
            p_lo  = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                                : {$urandom, $urandom};
            run_packet();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/v2p_ceu_req_dec.md
# v2p_ceu_req_dec

Receive-side decoder for the CEU write-request stream into the virtual-to-physical (V2P) subsystem. It accepts the CEU's head+payload packets and decodes type/opcode from the head:
- MTT write payload beats are split into single 64-bit MTT entry writes.
- ICM map payload beats are split into {virt, phys} chunk writes.
- MPT context beats are forwarded to the MPT table port.
- Payload-less commands (UNMAP_ICM, HW2SW_MPT) become single table commands.

It sits at the V2P ingress, directly behind the CEU write-request output.

## Interface
- TYPE_W, 4, head type field width (equals `AXIS_TYPE_WIDTH`)
- OPCODE_W, 4, head opcode field width (equals `AXIS_OPCODE_WIDTH`)
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- ceu_req_valid/ready/last  in/out/in  1  request stream handshake
- ceu_req_head  in  128  valid on first beat only: [127 -: TYPE_W] type, next OPCODE_W opcode, [95:64] count/index, [63:0] low word
- ceu_req_data  in  256  payload beat
- mtt_wr_valid/ready  out/in  1;  mtt_wr_index  out 64;  mtt_wr_data  out 64
- icm_map_valid/ready  out/in  1;  icm_map_virt  out 64;  icm_map_phys  out 64
- icm_unmap_valid/ready  out/in  1;  icm_unmap_virt  out 64;  icm_unmap_cnt  out 32
- mpt_wr_valid/ready  out/in  1;  mpt_wr_last  out 1;  mpt_wr_index  out 32;  mpt_wr_data  out 256
- mpt_inv_valid/ready  out/in  1;  mpt_inv_index  out 32
- err_pulse  out  1  one-cycle pulse on a malformed or unknown packet

## Operation
- States: IDLE, MTT_SPLIT, ICM_SPLIT, MPT_FWD, BARE, DRAIN.
- **IDLE**
  - ceu_req_ready=0.
  - When ceu_req_valid=1, latch the head into hdr_reg (cnt=head[95:64], lo=head[63:0]) and decode:
    - MAP_ICM_TPT/MAP_ICM_EN → ICM_SPLIT
    - MAP_ICM_TPT/MAP_ICM_DIS → BARE
    - WR_MPT_TPT/WR_MPT_WRITE → MPT_FWD
    - WR_MPT_TPT/WR_MPT_INVALID → BARE
    - WR_MTT_TPT/WR_MTT_WRITE → MTT_SPLIT, or DRAIN if cnt=0
    - anything else → DRAIN with err_pulse
- **MTT_SPLIT**
  - Sub-index k (0..3), idx=lo, rem=cnt.
  - mtt_wr_valid=1, mtt_wr_index=idx, mtt_wr_data=data[64k+:64].
  - On handshake: idx+1 (64-bit wrap), rem-1, k+1 mod 4.
  - Beat pop (ceu_req_ready=mtt_wr_ready) happens on the handshake where k=3 or rem=1.
  - Exit conditions:
    - rem reaches 0 on a last beat → IDLE.
    - rem reaches 0 on a non-last beat → DRAIN, no err.
    - Beat with last=1 popped while rem>0 → IDLE plus err_pulse.
- **ICM_SPLIT**
  - Two chunks per beat: chunk j (0..1) has virt=data[128j+63:128j], phys=data[128j+127:128j+64].
  - rem=cnt. Pop the beat when j=1 or rem=1.
  - End rules are identical to MTT. cnt=0 → DRAIN.
- **MPT_FWD**
  - Pass-through: mpt_wr_valid=ceu_req_valid, ceu_req_ready=mpt_wr_ready, data/last forwarded, mpt_wr_index=cnt.
  - Handshake with last → IDLE.
- **BARE**
  - Drives icm_unmap (virt=lo, cnt=cnt) or mpt_inv (index=cnt).
  - ceu_req_ready = the downstream ready, so the single beat is consumed with the command.
  - If that beat has last=0 → DRAIN.
- **DRAIN**
  - ceu_req_ready=1, no outputs driven.
  - Handshake with last → IDLE.
- Only one downstream valid is high at any time. Valid and payload stay stable until ready.
- Reset, or rst asserted mid-packet: state→IDLE, all counters cleared, every output 0. The remainder of an interrupted packet is the CEU's responsibility; upstream resets together with this block.

## Timing
- Head-to-first-command latency: 1 cycle (IDLE decode cycle). No bubble after that.
- Sustained throughput:
  - MTT: 1 entry/cycle, i.e. 1 beat per 4 cycles.
  - ICM: 1 chunk/cycle.
  - MPT: 1 beat/cycle.
- IDLE is re-entered for one cycle between packets, so there is a 1-cycle gap per packet.
- ceu_req_ready is combinational from the downstream ready. There is no combinational path from ceu_req_valid to downstream valid in split states (data is used directly, k/j and counters are registered).
- err_pulse is registered, asserted the cycle after the triggering event.

## Test plan
- **MTT write:** WR_MTT_WRITE, cnt=6, lo=0x100, two beats with entries A0..A3, B0..B3, last on beat 2, ready=1.
  - Expect 6 writes, index 0x100..0x105, data A0..A3, B0, B1.
  - Beat 1 popped at the 4th write, beat 2 at the 6th. No err. Back in IDLE.
- **ICM map with backpressure:** MAP_ICM_EN, cnt=3, two beats; icm_map_ready toggles 1/0.
  - Expect 3 chunks in order, each held stable while ready=0.
  - Beat pops on chunks 2 and 3.
- **MPT write:** WR_MPT_WRITE, index 0x2A, 8 beats.
  - Expect 8 mpt_wr beats, mpt_wr_last on beat 8, index 0x2A throughout.
  - Then WR_MPT_INVALID with index 0x2A → a single mpt_inv handshake.
- **Unmap:** MAP_ICM_DIS, cnt=16, lo=0xDEAD_0000, single last beat.
  - Expect one icm_unmap with cnt=16, virt=0xDEAD_0000. Beat consumed on that handshake.
- **Malformed packets:**
  - Unknown opcode, 3 beats → all drained, err_pulse once, no downstream valid.
  - MTT cnt=8 with only 1 beat (last) → 4 writes, then err_pulse.
  - MTT cnt=1 with 2 beats → 1 write, 2nd beat drained, no err.
- **Reset mid-stream:** rst pulsed during the 2nd MTT entry.
  - All valids drop asynchronously and the block is in IDLE.
  - A new WR_MTT_WRITE packet after reset decodes correctly from index=lo.
